// File: rtl/io_responder.sv
// io_responder: memory-mapped IO block for a soft core.
// It provides an LED register, a button-latched switch entry port, an output
// word with a valid/ack handshake, and sticky STATUS bits.
// The optional free-running CYCLE counter at 0x18 is built only when the
// macro IO_RESPONDER_CYCLE_CNT_EN is defined.
module io_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  input  logic [15:0] x,
  input  logic        btn_data,
  output logic [15:0] led,
  output logic [31:0] out_data,
  output logic        out_vld,
  input  logic        out_ack
);

  localparam logic [7:0] ADDR_LED      = 8'h00;
  localparam logic [7:0] ADDR_IN_RDY   = 8'h04;
  localparam logic [7:0] ADDR_IN_DATA  = 8'h08;
  localparam logic [7:0] ADDR_OUT_RDY  = 8'h0C;
  localparam logic [7:0] ADDR_OUT_DATA = 8'h10;
  localparam logic [7:0] ADDR_STATUS   = 8'h14;
`ifdef IO_RESPONDER_CYCLE_CNT_EN
  localparam logic [7:0] ADDR_CYCLE    = 8'h18;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] flush_q;
  logic                   btn_sync;
  logic                   btn_prev;
  logic                   btn_armed;
  logic                   in_pulse;

  logic [31:0] in_data;
  logic        in_vld;
  logic        in_overrun;
  logic        out_overflow;

  logic rd_eff;
  logic rd_in_data;
  logic status_clr;
  logic out_wr;
  logic out_accept;
  logic in_overrun_set;
  logic out_overflow_set;

  // A read is suppressed whenever a write shares the cycle.
  assign rd_eff           = io_rd & ~io_we;
  assign rd_in_data       = rd_eff && (io_addr == ADDR_IN_DATA);
  assign status_clr       = rd_eff && (io_addr == ADDR_STATUS);
  assign out_wr           = io_we && (io_addr == ADDR_OUT_DATA);
  assign out_accept       = out_wr & (~out_vld | out_ack);
  assign out_overflow_set = out_wr & out_vld & ~out_ack;
  assign in_overrun_set   = in_pulse & in_vld & ~rd_in_data;

  assign btn_sync = sync_q[SYNC_STAGES-1];
  // The edge detector only fires once it has seen the button released after reset.
  assign in_pulse = btn_sync & ~btn_prev & btn_armed;

  // Button synchroniser and edge detector.
  // flush_q marks when the synchroniser output reflects the real pin again, so that
  // a button held through reset is not taken for a release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= '0;
      flush_q   <= '0;
      btn_prev  <= 1'b0;
      btn_armed <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_data};
      flush_q   <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      btn_prev  <= btn_sync;
      if (flush_q[SYNC_STAGES-1] && !btn_sync)
        btn_armed <= 1'b1;
    end
  end

  // Entry port: latches the switches on each press and is cleared by a read of IN_DATA.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_data <= '0;
      in_vld  <= 1'b0;
    end else if (in_pulse) begin
      in_data <= {16'h0000, x};
      in_vld  <= 1'b1;
    end else if (rd_in_data) begin
      in_vld  <= 1'b0;
    end
  end

  // Output word handshake: an ack in the same cycle frees the slot for the new write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data <= '0;
      out_vld  <= 1'b0;
    end else if (out_accept) begin
      out_data <= io_dout;
      out_vld  <= 1'b1;
    end else if (out_ack && !out_wr) begin
      out_vld  <= 1'b0;
    end
  end

  // LED register and sticky status bits; a set event wins over a clear by read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led          <= '0;
      in_overrun   <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      if (io_we && (io_addr == ADDR_LED))
        led <= io_dout[15:0];
      if (in_overrun_set)
        in_overrun <= 1'b1;
      else if (status_clr)
        in_overrun <= 1'b0;
      if (out_overflow_set)
        out_overflow <= 1'b1;
      else if (status_clr)
        out_overflow <= 1'b0;
    end
  end

`ifdef IO_RESPONDER_CYCLE_CNT_EN
  logic [31:0] cycle_q;

  // Free-running cycle counter, zeroed by a write to CYCLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cycle_q <= '0;
    else if (io_we && (io_addr == ADDR_CYCLE))
      cycle_q <= '0;
    else
      cycle_q <= cycle_q + 32'd1;
  end
`endif

  // Read mux: purely combinational from io_addr; unmapped addresses read zero.
  always_comb begin
    io_din = '0;
    case (io_addr)
      ADDR_LED:      io_din = {16'h0000, led};
      ADDR_IN_RDY:   io_din = {31'b0, in_vld};
      ADDR_IN_DATA:  io_din = in_data;
      ADDR_OUT_RDY:  io_din = {31'b0, ~out_vld};
      ADDR_OUT_DATA: io_din = out_data;
      ADDR_STATUS:   io_din = {30'b0, in_overrun, out_overflow};
`ifdef IO_RESPONDER_CYCLE_CNT_EN
      ADDR_CYCLE:    io_din = cycle_q;
`endif
      default:       io_din = '0;
    endcase
  end

endmodule

// File: tb/tb_io_responder.sv
// Directed testbench for io_responder.
module tb_io_responder;
  localparam int unsigned SYNC_STAGES = 2;

  logic        clk;
  logic        rstn;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic        io_rd;
  logic [31:0] io_din;
  logic [15:0] x;
  logic        btn_data;
  logic [15:0] led;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_ack;

  int n_cmp;
  int n_fail;

  io_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rstn(rstn), .io_addr(io_addr), .io_dout(io_dout),
    .io_we(io_we), .io_rd(io_rd), .io_din(io_din), .x(x),
    .btn_data(btn_data), .led(led), .out_data(out_data),
    .out_vld(out_vld), .out_ack(out_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a write strobe for one cycle; returns 1 time unit after the edge.
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic ack);
    @(negedge clk);
    io_addr = a; io_dout = d; io_we = 1'b1; out_ack = ack;
    @(posedge clk); #1;
    io_we = 1'b0; out_ack = 1'b0;
  endtask

  // Drives a read strobe for one cycle; the data is sampled before the edge.
  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    io_addr = a; io_rd = 1'b1;
    #1 d = io_din;
    @(posedge clk); #1;
    io_rd = 1'b0;
  endtask

  // Side-effect-free look at the combinational read mux.
  task automatic peek(input logic [7:0] a, output logic [31:0] d);
    io_addr = a;
    #1 d = io_din;
  endtask

  task automatic press(input logic [15:0] val);
    @(negedge clk);
    x = val; btn_data = 1'b1;
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1;
  endtask

  task automatic release_btn();
    @(negedge clk);
    btn_data = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    for (int unsigned a = 0; a <= 8'h1C; a += 4) begin
      peek(8'(a), d);
      n_cmp++;
      if (d !== ((a == 32'h0C) ? 32'd1 : 32'd0)) begin
        n_fail++;
        $display("FAIL reset_read addr=%02h got=%08h want=%08h", a, d, (a == 32'h0C) ? 32'd1 : 32'd0);
      end
    end
    n_cmp++;
    if (led !== 16'h0 || out_vld !== 1'b0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs led=%h vld=%b data=%h want 0/0/0", led, out_vld, out_data);
    end
  endtask

  task automatic test_entry();
    logic [31:0] d;
    press(16'h1234);
    peek(8'h04, d);
    n_cmp++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL entry_rdy got=%08h want=00000001", d); end
    peek(8'h08, d);
    n_cmp++;
    if (d !== 32'h00001234) begin n_fail++; $display("FAIL entry_data got=%08h want=00001234", d); end
    bus_read(8'h08, d);
    peek(8'h04, d);
    n_cmp++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL entry_rdy_clr got=%08h want=00000000", d); end
    release_btn();
    peek(8'h04, d);
    n_cmp++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL entry_release_nopulse got=%08h want=00000000", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    press(16'h1111);
    release_btn();
    press(16'h2222);
    release_btn();
    peek(8'h08, d);
    n_cmp++;
    if (d !== 32'h00002222) begin n_fail++; $display("FAIL overrun_data got=%08h want=00002222", d); end
    bus_read(8'h14, d);
    n_cmp++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL overrun_status got=%08h want=00000002", d); end
    peek(8'h14, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL overrun_status_clr got=%08h want=00000000", d); end
    // Write and read together: the read side effect must not clear in_vld.
    @(negedge clk);
    io_addr = 8'h08; io_we = 1'b1; io_rd = 1'b1; io_dout = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    io_we = 1'b0; io_rd = 1'b0;
    peek(8'h04, d);
    n_cmp++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL we_rd_suppress got=%08h want=00000001", d); end
    bus_read(8'h08, d);
  endtask

  task automatic test_out();
    logic [31:0] d;
    bus_write(8'h10, 32'hDEADBEEF, 1'b0);
    n_cmp++;
    if (out_vld !== 1'b1 || out_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL out_write vld=%b data=%08h want 1/DEADBEEF", out_vld, out_data);
    end
    peek(8'h0C, d);
    n_cmp++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL out_rdy_busy got=%08h want=00000000", d); end
    bus_write(8'h10, 32'h00000001, 1'b0);
    peek(8'h10, d);
    n_cmp++;
    if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL out_overflow_data got=%08h want=DEADBEEF", d); end
    peek(8'h14, d);
    n_cmp++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL out_overflow_status got=%08h want=00000001", d); end
    bus_read(8'h14, d);
    bus_write(8'h10, 32'h00000055, 1'b1);
    peek(8'h14, d);
    n_cmp++;
    if (out_data !== 32'h55 || out_vld !== 1'b1 || d !== 32'h0) begin
      n_fail++; $display("FAIL out_ack_write data=%08h vld=%b status=%08h want 00000055/1/0", out_data, out_vld, d);
    end
    @(negedge clk); out_ack = 1'b1;
    @(posedge clk); #1; out_ack = 1'b0;
    peek(8'h0C, d);
    n_cmp++;
    if (out_vld !== 1'b0 || d !== 32'd1) begin
      n_fail++; $display("FAIL out_ack_clear vld=%b rdy=%08h want 0/00000001", out_vld, d);
    end
    @(negedge clk); out_ack = 1'b1;
    @(posedge clk); #1; out_ack = 1'b0;
    n_cmp++;
    if (out_vld !== 1'b0 || out_data !== 32'h55) begin
      n_fail++; $display("FAIL out_ack_idle vld=%b data=%08h want 0/00000055", out_vld, out_data);
    end
  endtask

  task automatic test_led_async_reset();
    logic [31:0] d;
    bus_write(8'h00, 32'hFFFFABCD, 1'b0);
    peek(8'h00, d);
    n_cmp++;
    if (led !== 16'hABCD || d !== 32'h0000ABCD) begin
      n_fail++; $display("FAIL led_write led=%h rd=%08h want ABCD/0000ABCD", led, d);
    end
    bus_write(8'h3C, 32'h12345678, 1'b0);
    peek(8'h3C, d);
    n_cmp++;
    if (d !== 32'h0 || led !== 16'hABCD) begin
      n_fail++; $display("FAIL unmapped rd=%08h led=%h want 00000000/ABCD", d, led);
    end
    bus_write(8'h10, 32'hCAFE0001, 1'b0);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (led !== 16'h0 || out_vld !== 1'b0) begin
      n_fail++; $display("FAIL async_reset led=%h vld=%b want 0000/0", led, out_vld);
    end
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_button_held();
    logic [31:0] d;
    @(negedge clk);
    x = 16'hBEEF; btn_data = 1'b1;
    do_reset();
    repeat (10) @(posedge clk); #1;
    peek(8'h04, d);
    n_cmp++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL held_through_reset got=%08h want=00000000", d); end
    release_btn();
    press(16'h4321);
    peek(8'h08, d);
    n_cmp++;
    if (d !== 32'h00004321) begin n_fail++; $display("FAIL held_then_press got=%08h want=00004321", d); end
    release_btn();
    bus_read(8'h08, d);
  endtask

  task automatic test_cycle();
    logic [31:0] d;
    bus_write(8'h18, 32'hFFFF_FFFF, 1'b0);
    repeat (10) @(posedge clk); #1;
    peek(8'h18, d);
`ifdef IO_RESPONDER_CYCLE_CNT_EN
    n_cmp++;
    if (d !== 32'd10) begin n_fail++; $display("FAIL cycle_count got=%08h want=0000000a", d); end
`else
    n_cmp++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL cycle_unmapped got=%08h want=00000000", d); end
`endif
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rstn = 1'b0; io_addr = '0; io_dout = '0; io_we = 1'b0; io_rd = 1'b0;
    x = '0; btn_data = 1'b0; out_ack = 1'b0;
    test_reset();
    test_entry();
    test_overrun();
    test_out();
    test_led_async_reset();
    test_button_held();
    test_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flop stages synchronising btn_data (legal 2..4).
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 io_addr  input  8  IO register byte address from core.
REQ-005 io_dout  input  32  write data from core.
REQ-006 io_we  input  1  write strobe, one cycle per access.
REQ-007 io_rd  input  1  read strobe, one cycle per access.
REQ-008 io_din  output  32  read data to core.
REQ-009 x  input  16  switch value.
REQ-010 btn_data  input  1  raw, asynchronous, debounced entry button.
REQ-011 led  output  16  LED register.
REQ-012 out_data  output  32  display data to consumer.
REQ-013 out_vld  output  1  out_data holds unconsumed word.
REQ-014 out_ack  input  1  consumer one-cycle pulse, word taken.

Function
REQ-015 Register map: 0x00 LED(rw), 0x04 IN_RDY(r), 0x08 IN_DATA(r), 0x0C OUT_RDY(r), 0x10 OUT_DATA(rw), 0x14 STATUS(r), 0x18 CYCLE(rw).
REQ-016 io_din is combinational from io_addr in the same cycle, independent of io_rd.
REQ-017 Unmapped address: io_din = 0; writes ignored; no side effects.
REQ-018 Write 0x00: led <= io_dout[15:0] on the strobe edge; read returns {16'b0, led}.
REQ-019 btn_data passes SYNC_STAGES flops, then rising-edge detector: one-cycle pulse per press.
REQ-020 Entry pulse: in_data <= {16'b0, x}, in_vld <= 1; if in_vld already 1, also set STATUS[1] (in_overrun).
REQ-021 Read 0x04 returns {31'b0, in_vld}; read 0x08 returns in_data.
REQ-022 io_rd at 0x08 clears in_vld at that edge; a same-edge entry pulse wins: in_vld stays 1, new data loaded, no overrun.
REQ-023 Read 0x0C returns {31'b0, ~out_vld}.
REQ-024 Write 0x10, out_vld=0: out_data <= io_dout, out_vld <= 1 at that edge.
REQ-025 Write 0x10, out_vld=1, no out_ack: write dropped, out_data unchanged, STATUS[0] (out_overflow) set.
REQ-026 Write 0x10 with same-cycle out_ack, out_vld=1: new word accepted, out_vld stays 1, no overflow.
REQ-027 out_ack with out_vld=1 and no write clears out_vld next edge; out_ack with out_vld=0 ignored.
REQ-028 Read 0x10 returns out_data.
REQ-029 STATUS bits sticky; io_rd at 0x14 clears both at that edge; a same-edge set event wins.
REQ-030 io_we and io_rd both high: write executes, read side effects suppressed.
REQ-031 out_data and out_vld change only on clk edges.

Reset
REQ-032 rstn low asynchronously clears led, in_data, in_vld, out_data, out_vld, STATUS, CYCLE, sync and edge flops.
REQ-033 Assertion mid-handshake discards pending word: out_vld=0 immediately, no ack required.
REQ-034 After deassertion no entry pulse from a button held through reset until released and pressed again.
REQ-035 io_din equals 0 at reset for all addresses except 0x0C, which reads 1.

Configuration
REQ-036 Macro IO_RESPONDER_CYCLE_CNT_EN defined: CYCLE is 32-bit free-running, +1 per clk, wraps 0xFFFFFFFF->0; write 0x18 loads 0 at that edge; read returns count.
REQ-037 Macro undefined: no counter logic; 0x18 treated as unmapped (reads 0, writes ignored).

Verification
REQ-038 Reset, x=16'h1234, press btn_data -> within SYNC_STAGES+2 cycles read 0x04=1, 0x08=0x00001234; after read 0x08, 0x04=0.
REQ-039 Press twice, no read -> 0x08 = second x, STATUS=0x2; read STATUS -> next STATUS read 0.
REQ-040 Write 0x10=0xDEADBEEF -> out_vld=1, out_data=0xDEADBEEF, 0x0C=0; write 0x10=0x1 before ack -> out_data unchanged, STATUS=0x1.
REQ-041 out_vld=1, write 0x10=0x55 with out_ack same cycle -> out_data=0x55, out_vld=1, STATUS=0.
REQ-042 Write 0x00=0xFFFFABCD -> led=16'hABCD; read 0x3C -> 0; rstn pulse low mid-cycle -> led=0, out_vld=0 without clock edge.
REQ-043 CYCLE_CNT_EN defined: write 0x18, idle 10 cycles, read -> 10 (+/- bus latency fixed at 0); undefined: read 0x18 -> 0.
